// File: rtl/program_loader.sv
// UART-fed instruction memory loader. It holds the core while a length-framed program is written.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module program_loader #(
    parameter int unsigned IMEM_ADDR_W    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flash,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_hold,
    output logic                   load_done,
    output logic                   load_error,
    output logic [IMEM_ADDR_W:0]   words_loaded
);

    localparam int unsigned CntW = IMEM_ADDR_W + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StDone,
        StError
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , StCheck
`endif
    } state_e;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e StFinal = StCheck;
`else
    localparam state_e StFinal = StDone;
`endif

    state_e                 state_q, state_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic [CntW-1:0]        len_q, len_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            asm_q, asm_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [CntW-1:0]        words_q, words_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [15:0]            n_len;
    logic                   timed_out;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            words_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            words_q  <= words_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        words_d   = words_q;
        err_d     = err_q;
        done_d    = 1'b0;
        tmo_d     = tmo_q;
        n_len     = {rx_byte, len_lo_q};
        timed_out = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        // Idle-gap timer only runs once the length low byte is in.
        if (state_q == StLenHi || state_q == StData || state_q == StFinal) begin
            tmo_d = rx_valid ? '0 : tmo_q + TmoW'(1);
        end

        case (state_q)
            StIdle: begin
                if (flash) begin
                    state_d = StLenLo;
                    err_d   = 1'b0;
                    words_d = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StLenLo: begin
                if (!flash) begin
                    state_d = StIdle;
                end else if (rx_valid) begin
                    len_lo_d = rx_byte;
                    tmo_d    = '0;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (!flash) begin
                    state_d = StError;
                end else if (rx_valid) begin
                    len_d = CntW'(n_len);
                    if (n_len == 16'd0) begin
                        state_d = StFinal;
                    end else if (32'(n_len) > (32'd1 << IMEM_ADDR_W)) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (!flash) begin
                    state_d = StError;
                end else if (rx_valid) begin
                    idx_d = idx_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_byte;
`endif
                    case (idx_q)
                        2'd0: asm_d[7:0]   = rx_byte;
                        2'd1: asm_d[15:8]  = rx_byte;
                        2'd2: asm_d[23:16] = rx_byte;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_byte, asm_q};
                            addr_d  = words_q[IMEM_ADDR_W-1:0];
                            words_d = words_q + CntW'(1);
                            if (words_d == len_q) begin
                                state_d = StFinal;
                            end
                        end
                    endcase
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (!flash) begin
                    state_d = StError;
                end else if (rx_valid) begin
                    state_d = (rx_byte == csum_q) ? StDone : StError;
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
`endif
            StDone, StError: begin
                if (!flash) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StError) begin
            err_d = 1'b1;
            we_d  = 1'b0;
        end
        if (state_d == StDone && state_q != StDone) begin
            done_d = 1'b1;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_hold    = (state_q != StIdle);
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Controller that sequences instruction-memory programming from the UART byte stream while the pipeline is held.
- Sits between the uart receiver (data_valid/data_packet) and the fetch stage's instruction memory write port.
- Drives core_hold so the pipeline registers and PC stay in reset until a complete program has been written.
- Replaces ad-hoc byte handling in fetch with a framed, length-checked, timeout-protected load protocol.

Parameters:
IMEM_ADDR_W, 10, instruction memory word-address width (depth 2**IMEM_ADDR_W words)
TIMEOUT_CYCLES, 50_000_000, max idle cycles between bytes once a frame has started

Ports:
clk  in  1  core clock (clk_wiz output)
rst  in  1  synchronous, active-low reset
flash  in  1  level request: high = load mode
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received UART byte
imem_we  out  1  instruction memory write enable (one cycle per word)
imem_addr  out  IMEM_ADDR_W  word address for write
imem_wdata  out  32  word to write
core_hold  out  1  high = pipeline/PC held in reset
load_done  out  1  one-cycle pulse on successful completion
load_error  out  1  sticky error flag
words_loaded  out  IMEM_ADDR_W+1  count of words written in current/last load

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs 0 except core_hold=0. Byte/word counters and timeout cleared.
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, each word little-endian (first byte -> bits 7:0).
- States:
  - IDLE: core_hold=0. flash rising level (flash==1) -> LEN_LO; clears load_error, words_loaded, addr.
  - LEN_LO: core_hold=1. Waits indefinitely; rx_valid latches len[7:0] -> LEN_HI.
  - LEN_HI: rx_valid latches len[15:8]. N==0 -> DONE. N > 2**IMEM_ADDR_W -> ERROR. Otherwise -> DATA.
  - DATA: bytes shift into a 2-bit-indexed assembly register. On the 4th byte, the next cycle asserts imem_we=1 for exactly one cycle, with imem_addr=current word index and imem_wdata=assembled word. words_loaded increments in that same cycle. After word N is written -> DONE (or CHECK, see option).
  - DONE: load_done=1 for the entry cycle only; core_hold stays 1 until flash==0, then -> IDLE (core released the next cycle, PC starts at 0).
  - ERROR: load_error=1 (sticky until the next load start or reset), imem_we=0, core_hold=1. flash==0 -> IDLE.
- Timeout: counter cleared on every accepted byte, counts only in LEN_HI/DATA/CHECK. Reaching TIMEOUT_CYCLES -> ERROR.
- flash deasserted in LEN_HI/DATA/CHECK -> ERROR. flash deasserted in LEN_LO -> IDLE, no error.
- rx_valid in IDLE, DONE or ERROR is ignored.
- A byte arriving in the same cycle as imem_we is accepted; the assembly register is independent of the write.
- imem_addr wraps never: the length check guarantees the final address is <= 2**IMEM_ADDR_W-1.
- Reset asserted mid-load aborts immediately. Partially written memory contents are left as-is.

Optional Feature:
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined: after the last data byte, state CHECK expects one more byte equal to the XOR of all 4*N data bytes. Match -> DONE; mismatch -> ERROR. For N==0 the expected checksum is 0x00.
- Undefined: no CHECK state; the last word write goes directly to DONE.

Test Plan:
1. Reset with rst=0 for 2 cycles -> core_hold=0, imem_we=0, load_error=0, words_loaded=0.
2. flash=1; bytes 02 00 | 13 05 10 00 | 6F 00 00 00 -> writes addr0=0x00100513, addr1=0x0000006F; each imem_we is 1 cycle; load_done pulses once; words_loaded=2; core_hold drops 1 cycle after flash=0.
3. flash=1; length 00 00 -> DONE with no imem_we; with CHECKSUM_EN, checksum byte 00 is required before DONE.
4. IMEM_ADDR_W=10; length 01 04 (N=1025) -> ERROR, load_error=1, no writes; next flash cycle clears load_error.
5. Send length 01 00 plus 2 data bytes, then silence for TIMEOUT_CYCLES -> ERROR; then flash=0 -> IDLE, load_error stays 1.
6. CHECKSUM_EN: N=1, data AA 55 0F F0, checksum 00 -> DONE; same frame with checksum 01 -> ERROR after the write to addr0.
